// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// ALU op codes here must match the downstream ALU.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EX,
    S_R_WB,
    S_I_EX,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    AC_ADD,
    AC_SUB,
    AC_RTYPE,
    AC_ITYPE
  } alu_cls_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_LT  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps the current state class plus opcode/funct to an ALU op,
// and flags whether the instruction is one we can execute.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  alu_cls_e    i_cls,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_control,
  output logic        o_legal
);

  logic [2:0] w_r_alu;
  logic       w_r_ok;
  logic [2:0] w_i_alu;
  logic       w_i_ok;

  always_comb begin
    w_r_alu = ALU_ADD;
    w_r_ok  = 1'b1;
    case (i_funct)
      FN_ADD:  w_r_alu = ALU_ADD;
      FN_SUB:  w_r_alu = ALU_SUB;
      FN_AND:  w_r_alu = ALU_AND;
      FN_OR:   w_r_alu = ALU_OR;
      FN_SLT:  w_r_alu = ALU_LT;
      default: w_r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    w_i_alu = ALU_ADD;
    w_i_ok  = 1'b1;
    case (i_opcode)
      OP_ADDI: w_i_alu = ALU_ADD;
      OP_ANDI: w_i_alu = ALU_AND;
      OP_ORI:  w_i_alu = ALU_OR;
      OP_SLTI: w_i_alu = ALU_LT;
      default: w_i_ok  = 1'b0;
    endcase
  end

  always_comb begin
    o_legal = w_i_ok;
    case (i_opcode)
      OP_RTYPE: o_legal = w_r_ok;
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J:
        o_legal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    o_alu_control = ALU_ADD;
    unique case (i_cls)
      AC_ADD:   o_alu_control = ALU_ADD;
      AC_SUB:   o_alu_control = ALU_SUB;
      AC_RTYPE: o_alu_control = w_r_alu;
      AC_ITYPE: o_alu_control = w_i_alu;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle MIPS datapath with a
// ready/timeout memory handshake and a sticky bus error.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter  int MEM_TIMEOUT = 16,
  localparam int TW = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);

  state_e        r_state;
  logic [TW-1:0] r_cnt;
  logic          r_bus_err;

  alu_cls_e   w_cls;
  logic       w_legal;
  logic       w_wait;
  logic       w_last;
  logic       w_is_mem;
  logic       w_is_r;
  logic       w_is_br;
  logic       w_is_j;
  logic       w_is_i;

  assign w_wait = (r_state == S_FETCH)
               || (r_state == S_MEM_RD)
               || (r_state == S_MEM_WR);
  assign w_last = (r_cnt == TW'(MEM_TIMEOUT - 1));

  assign w_is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign w_is_r   = (opcode == OP_RTYPE);
  assign w_is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign w_is_j   = (opcode == OP_J);
  assign w_is_i   = w_legal
                 && !(w_is_mem || w_is_r || w_is_br || w_is_j);

  always_comb begin
    w_cls = AC_ADD;
    case (r_state)
      S_R_EX:   w_cls = AC_RTYPE;
      S_I_EX:   w_cls = AC_ITYPE;
      S_BRANCH: w_cls = AC_SUB;
      default:  w_cls = AC_ADD;
    endcase
  end

  alu_op_decoder u_alu_dec (
    .i_cls         (w_cls),
    .i_opcode      (opcode),
    .i_funct       (funct),
    .o_alu_control (alu_control),
    .o_legal       (w_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (!w_wait) r_cnt <= '0;
      unique case (r_state)
        S_RST: r_state <= S_FETCH;
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            r_cnt <= '0;
            unique case (r_state)
              S_FETCH:  r_state <= S_DECODE;
              S_MEM_RD: r_state <= S_MEM_WB;
              default:  r_state <= S_FETCH;
            endcase
          end else if (w_last) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          unique case (1'b1)
            !w_legal:           r_state <= S_FETCH;
            w_legal && w_is_mem: r_state <= S_MEM_ADDR;
            w_legal && w_is_r:   r_state <= S_R_EX;
            w_legal && w_is_br:  r_state <= S_BRANCH;
            w_legal && w_is_j:   r_state <= S_JUMP;
            w_is_i:              r_state <= S_I_EX;
            default:             r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:
          r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_R_EX:   r_state <= S_R_WB;
        S_I_EX:   r_state <= S_I_WB;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  assign bus_err = r_bus_err;

  // Moore decode; only pc_en and handshake strobes look at inputs.
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 2'd0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        illegal   = !w_legal;
      end
      S_MEM_ADDR, S_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EX: alu_src_a = 1'b1;
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        pc_src     = 2'd1;
        pc_en      = (opcode == OP_BEQ) ? zero : !zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      S_RST, S_HALT: ;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller.
// Each row drives one cycle's inputs and checks that cycle's outputs.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_en;
  logic [1:0] pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       instr_done;
  logic       illegal;
  logic       bus_err;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .pc_src      (pc_src),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  vec_t  tv[$];
  outs_t act;
  int    n_vec = 0;
  int    n_bad = 0;

  assign act = {pc_en, pc_src, i_or_d, mem_read, mem_write,
                ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_control,
                instr_done, illegal, bus_err};

  outs_t Z, FW, FR, DEC, DEC_ILL, MA, MRD, MWB, MWW, MWR;
  outs_t REX_ADD, REX_LT, RWB, IEX_ORI, IWB;
  outs_t BR_T, BR_N, JMP, HALT_E;

  task automatic check(input string nm, input outs_t e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", nm, act, e);
    end
  endtask

  function automatic void add(input logic r, input logic [5:0] op,
                              input logic [5:0] fn, input logic z,
                              input logic rdy, input outs_t e);
    vec_t v;
    v.rst_n = r;
    v.op    = op;
    v.fn    = fn;
    v.z     = z;
    v.rdy   = rdy;
    v.exp   = e;
    tv.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int cyc;

    Z = '0;
    FW = '0; FW.mem_read = 1; FW.alu_src_b = 2'd1;
    FR = FW; FR.ir_write = 1; FR.pc_en = 1;
    DEC = '0; DEC.alu_src_b = 2'd3;
    DEC_ILL = DEC; DEC_ILL.illegal = 1;
    MA = '0; MA.alu_src_a = 1; MA.alu_src_b = 2'd2;
    MRD = '0; MRD.mem_read = 1; MRD.i_or_d = 1;
    MWB = '0; MWB.reg_write = 1; MWB.mem_to_reg = 1;
    MWB.instr_done = 1;
    MWW = '0; MWW.mem_write = 1; MWW.i_or_d = 1;
    MWR = MWW; MWR.instr_done = 1;
    REX_ADD = '0; REX_ADD.alu_src_a = 1;
    REX_LT = REX_ADD; REX_LT.alu_control = 3'd4;
    RWB = '0; RWB.reg_write = 1; RWB.reg_dst = 1;
    RWB.instr_done = 1;
    IEX_ORI = MA; IEX_ORI.alu_control = 3'd3;
    IWB = '0; IWB.reg_write = 1; IWB.instr_done = 1;
    BR_N = '0; BR_N.alu_src_a = 1; BR_N.alu_control = 3'd1;
    BR_N.pc_src = 2'd1; BR_N.instr_done = 1;
    BR_T = BR_N; BR_T.pc_en = 1;
    JMP = '0; JMP.pc_src = 2'd2; JMP.pc_en = 1;
    JMP.instr_done = 1;
    HALT_E = '0; HALT_E.bus_err = 1;

    // reset, then add with memory always ready
    add(0, 6'h00, 6'h20, 0, 0, Z);
    add(1, 6'h00, 6'h20, 0, 1, Z);
    add(1, 6'h00, 6'h20, 0, 1, FR);
    add(1, 6'h00, 6'h20, 0, 1, DEC);
    add(1, 6'h00, 6'h20, 0, 1, REX_ADD);
    add(1, 6'h00, 6'h20, 0, 1, RWB);
    // lw with three wait cycles in MEM_RD
    add(1, 6'h23, 6'h00, 0, 1, FR);
    add(1, 6'h23, 6'h00, 0, 1, DEC);
    add(1, 6'h23, 6'h00, 0, 1, MA);
    add(1, 6'h23, 6'h00, 0, 0, MRD);
    add(1, 6'h23, 6'h00, 0, 0, MRD);
    add(1, 6'h23, 6'h00, 0, 0, MRD);
    add(1, 6'h23, 6'h00, 0, 1, MRD);
    add(1, 6'h23, 6'h00, 0, 1, MWB);
    // beq taken, bne not taken, both with zero=1
    add(1, 6'h04, 6'h00, 1, 1, FR);
    add(1, 6'h04, 6'h00, 1, 1, DEC);
    add(1, 6'h04, 6'h00, 1, 1, BR_T);
    add(1, 6'h05, 6'h00, 1, 1, FR);
    add(1, 6'h05, 6'h00, 1, 1, DEC);
    add(1, 6'h05, 6'h00, 1, 1, BR_N);
    // illegal opcode
    add(1, 6'h3F, 6'h00, 0, 1, FR);
    add(1, 6'h3F, 6'h00, 0, 1, DEC_ILL);
    // ori
    add(1, 6'h0D, 6'h00, 0, 1, FR);
    add(1, 6'h0D, 6'h00, 0, 1, DEC);
    add(1, 6'h0D, 6'h00, 0, 1, IEX_ORI);
    add(1, 6'h0D, 6'h00, 0, 1, IWB);
    // j
    add(1, 6'h02, 6'h00, 0, 1, FR);
    add(1, 6'h02, 6'h00, 0, 1, DEC);
    add(1, 6'h02, 6'h00, 0, 1, JMP);
    // slt
    add(1, 6'h00, 6'h2A, 0, 1, FR);
    add(1, 6'h00, 6'h2A, 0, 1, DEC);
    add(1, 6'h00, 6'h2A, 0, 1, REX_LT);
    add(1, 6'h00, 6'h2A, 0, 1, RWB);
    // R-type with unsupported funct
    add(1, 6'h00, 6'h21, 0, 1, FR);
    add(1, 6'h00, 6'h21, 0, 1, DEC_ILL);
    // sw: ready arrives on the timeout cycle and wins
    add(1, 6'h2B, 6'h00, 0, 1, FR);
    add(1, 6'h2B, 6'h00, 0, 1, DEC);
    add(1, 6'h2B, 6'h00, 0, 1, MA);
    add(1, 6'h2B, 6'h00, 0, 0, MWW);
    add(1, 6'h2B, 6'h00, 0, 0, MWW);
    add(1, 6'h2B, 6'h00, 0, 0, MWW);
    add(1, 6'h2B, 6'h00, 0, 1, MWR);
    // sw aborted by reset mid MEM_WR
    add(1, 6'h2B, 6'h00, 0, 1, FR);
    add(1, 6'h2B, 6'h00, 0, 1, DEC);
    add(1, 6'h2B, 6'h00, 0, 1, MA);
    add(1, 6'h2B, 6'h00, 0, 0, MWW);
    add(0, 6'h2B, 6'h00, 0, 0, Z);
    add(1, 6'h2B, 6'h00, 0, 1, Z);
    // fetch timeout -> HALT with sticky bus_err
    add(1, 6'h00, 6'h20, 0, 0, FW);
    add(1, 6'h00, 6'h20, 0, 0, FW);
    add(1, 6'h00, 6'h20, 0, 0, FW);
    add(1, 6'h00, 6'h20, 0, 0, FW);
    add(1, 6'h00, 6'h20, 0, 1, HALT_E);
    add(1, 6'h00, 6'h20, 0, 1, HALT_E);
    add(0, 6'h00, 6'h20, 0, 1, Z);
    add(1, 6'h00, 6'h20, 0, 1, Z);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst_n     = tv[i].rst_n;
      opcode    = tv[i].op;
      funct     = tv[i].fn;
      zero      = tv[i].z;
      mem_ready = tv[i].rdy;
      #1;
      check($sformatf("vec%0d", i), tv[i].exp);
    end

    // add retires on its 4th cycle counting from FETCH
    @(negedge clk);
    opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      #1;
      if (instr_done) begin
        got = 1'b1;
        cyc = i;
      end else begin
        @(negedge clk);
      end
    end
    n_vec++;
    if (!got || cyc != 4) begin
      n_bad++;
      $display("FAIL add_latency: got %0d (seen %0d) expected 4",
               cyc, got);
    end

    // beq pc_en follows zero combinationally within BRANCH
    @(negedge clk);
    opcode = 6'h04; zero = 1'b0;
    #1 check("beq_fetch", FR);
    @(negedge clk);
    #1 check("beq_decode", DEC);
    @(negedge clk);
    #1 check("beq_z0", BR_N);
    zero = 1'b1;
    #1 check("beq_z1", BR_T);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
